stream_mux_n: RTL and testbench

- Parametrised N:1 multiplexer with a registered output and valid/ready handshake on every port; next generation of the 2:1 combinational mux.
- Generalised in data width and channel count.
- Adds two selection modes: external select, or internal round-robin arbitration.
- Sits between several producer streams and a single consumer; one-entry output buffer, one transfer per cycle at full throughput.

---
 rtl/stream_mux_n_pkg.sv | 17 +
 rtl/stream_mux_n_if.sv | 29 ++
 rtl/stream_mux_n_rr_arbiter.sv | 30 +++
 rtl/stream_mux_n.sv | 106 ++++++++++
 tb/tb_stream_mux_n.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_n_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
package stream_mux_n_pkg;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned sel_width(int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Producer-side and consumer-side stream signals of the N:1 multiplexer.
interface stream_mux_n_if import stream_mux_n_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = sel_width(NCH)
);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  // Producers and consumer side.
  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester after ptr_i, wrapping around.
module stream_mux_n_rr_arbiter #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    // Wrapped half first (0..ptr); any hit above ptr then overrides it.
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (req_i[i] && (i <= int'(ptr_i))) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = SELW'(i);
      end
    end
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (req_i[i] && (i > int'(ptr_i))) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = SELW'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N:1 valid/ready stream multiplexer with a one-entry registered output stage and
// either external select or round-robin channel choice.
module stream_mux_n import stream_mux_n_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned MODE  = MODE_SEL,
  parameter int unsigned SELW  = sel_width(NCH)
) (
  input logic           clk,
  input logic           rst_n,
  stream_mux_n_if.slave bus
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = !valid_q || bus.out_ready;

  if (MODE == MODE_RR) begin : g_rr
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            unused_sel;

    assign unused_sel = ^bus.sel;

    stream_mux_n_rr_arbiter #(
      .NCH  (NCH),
      .SELW (SELW)
    ) u_arb (
      .req_i     (bus.in_valid),
      .ptr_i     (ptr_q),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
    );

    // Pointer moves only on an accepted transfer.
    assign ptr_d = (load_en && gnt_vld) ? gnt_idx : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr_q <= SELW'(NCH - 1);
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end else begin : g_sel
    // Out-of-range select matches no channel and therefore never grants.
    always_comb begin
      gnt_idx = bus.sel;
      gnt_vld = 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (bus.sel == SELW'(i)) begin
          gnt_vld = bus.in_valid[i];
        end
      end
    end
  end

  always_comb begin
    gnt_data     = '0;
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data        = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_ready[i] = rst_n && load_en && gnt_vld;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (load_en) begin
      if (gnt_vld) begin
        data_d  = gnt_data;
        ch_d    = gnt_idx;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: select mode (4 and 3 channels) and round-robin mode side by side.
module tb_stream_mux_n;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] d;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  item_t qs[$];
  item_t qr[$];
  item_t q3[$];
  logic  pv_s = 1'b0;
  logic  pv_r = 1'b0;
  logic  pv_3 = 1'b0;

  always #5 clk = ~clk;

  stream_mux_n_if #(.WIDTH(8), .NCH(4)) bs ();
  stream_mux_n_if #(.WIDTH(8), .NCH(4)) br ();
  stream_mux_n_if #(.WIDTH(8), .NCH(3)) b3 ();

  stream_mux_n #(.WIDTH(8), .NCH(4), .MODE(0)) u_s (.clk(clk), .rst_n(rst_n), .bus(bs));
  stream_mux_n #(.WIDTH(8), .NCH(4), .MODE(1)) u_r (.clk(clk), .rst_n(rst_n), .bus(br));
  stream_mux_n #(.WIDTH(8), .NCH(3), .MODE(0)) u_3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  // Scoreboards: just after each edge, retire the word consumed at that edge, then
  // the head of the queue is what the output register must hold.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      qs.delete();
      pv_s = 1'b0;
    end else begin
      if (pv_s && bs.out_ready && qs.size() != 0) void'(qs.pop_front());
      total++;
      if (bs.out_valid !== (qs.size() != 0)) begin
        bad++;
        $display("FAIL sb_s_valid got=%b want=%b", bs.out_valid, qs.size() != 0);
      end
      if (qs.size() != 0) begin
        total++;
        if (bs.out_data !== qs[0].d || bs.out_ch !== qs[0].ch) begin
          bad++;
          $display("FAIL sb_s_word got=%h/ch%0d want=%h/ch%0d", bs.out_data, bs.out_ch,
                   qs[0].d, qs[0].ch);
        end
      end
      pv_s = bs.out_valid;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      qr.delete();
      pv_r = 1'b0;
    end else begin
      if (pv_r && br.out_ready && qr.size() != 0) void'(qr.pop_front());
      total++;
      if (br.out_valid !== (qr.size() != 0)) begin
        bad++;
        $display("FAIL sb_r_valid got=%b want=%b", br.out_valid, qr.size() != 0);
      end
      if (qr.size() != 0) begin
        total++;
        if (br.out_data !== qr[0].d || br.out_ch !== qr[0].ch) begin
          bad++;
          $display("FAIL sb_r_word got=%h/ch%0d want=%h/ch%0d", br.out_data, br.out_ch,
                   qr[0].d, qr[0].ch);
        end
      end
      pv_r = br.out_valid;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q3.delete();
      pv_3 = 1'b0;
    end else begin
      if (pv_3 && b3.out_ready && q3.size() != 0) void'(q3.pop_front());
      total++;
      if (b3.out_valid !== (q3.size() != 0)) begin
        bad++;
        $display("FAIL sb_3_valid got=%b want=%b", b3.out_valid, q3.size() != 0);
      end
      if (q3.size() != 0) begin
        total++;
        if (b3.out_data !== q3[0].d || b3.out_ch !== q3[0].ch) begin
          bad++;
          $display("FAIL sb_3_word got=%h/ch%0d want=%h/ch%0d", b3.out_data, b3.out_ch,
                   q3[0].d, q3[0].ch);
        end
      end
      pv_3 = b3.out_valid;
    end
  end

  // Drivers: apply inputs for the next edge; exp_ch >= 0 means a transfer is expected.
  task automatic drv_s(input logic [1:0] sel, input logic [3:0] v, input logic [31:0] d,
                       input logic rdy, input int exp_ch);
    item_t it;
    @(posedge clk);
    #2;
    bs.sel = sel; bs.in_valid = v; bs.in_data = d; bs.out_ready = rdy;
    if (exp_ch >= 0) begin
      it.ch = 2'(exp_ch);
      it.d  = d[exp_ch*8 +: 8];
      qs.push_back(it);
    end
  endtask

  task automatic drv_r(input logic [3:0] v, input logic [31:0] d, input logic rdy,
                       input int exp_ch);
    item_t it;
    @(posedge clk);
    #2;
    br.in_valid = v; br.in_data = d; br.out_ready = rdy;
    if (exp_ch >= 0) begin
      it.ch = 2'(exp_ch);
      it.d  = d[exp_ch*8 +: 8];
      qr.push_back(it);
    end
  endtask

  task automatic drv_3(input logic [1:0] sel, input logic [2:0] v, input logic [23:0] d,
                       input logic rdy, input int exp_ch);
    item_t it;
    @(posedge clk);
    #2;
    b3.sel = sel; b3.in_valid = v; b3.in_data = d; b3.out_ready = rdy;
    if (exp_ch >= 0) begin
      it.ch = 2'(exp_ch);
      it.d  = d[exp_ch*8 +: 8];
      q3.push_back(it);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    br.in_valid = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    total += 9;
    if (bs.out_valid !== 1'b0) begin bad++; $display("FAIL rst_s_valid got=%b want=0", bs.out_valid); end
    if (bs.out_data !== 8'h00) begin bad++; $display("FAIL rst_s_data got=%h want=00", bs.out_data); end
    if (bs.out_ch !== 2'd0) begin bad++; $display("FAIL rst_s_ch got=%0d want=0", bs.out_ch); end
    if (bs.in_ready !== 4'b0) begin bad++; $display("FAIL rst_s_rdy got=%b want=0000", bs.in_ready); end
    if (br.out_valid !== 1'b0) begin bad++; $display("FAIL rst_r_valid got=%b want=0", br.out_valid); end
    if (br.out_data !== 8'h00) begin bad++; $display("FAIL rst_r_data got=%h want=00", br.out_data); end
    if (br.out_ch !== 2'd0) begin bad++; $display("FAIL rst_r_ch got=%0d want=0", br.out_ch); end
    if (br.in_ready !== 4'b0) begin bad++; $display("FAIL rst_r_rdy got=%b want=0000", br.in_ready); end
    if (b3.in_ready !== 3'b0) begin bad++; $display("FAIL rst_3_rdy got=%b want=000", b3.in_ready); end
    bs.in_valid = '0; br.in_valid = '0; b3.in_valid = '0;
    rst_n = 1'b1;
    drv_r(4'b1111, 32'hD4C3B2A1, 1'b1, 0);
    #1;
    total++;
    if (br.in_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_rdy got=%b want=0001", br.in_ready); end
    drv_r(4'b0000, 32'h0, 1'b1, -1);
  endtask

  task automatic test_sel_basic();
    drv_s(2'd2, 4'b1111, 32'h44332211, 1'b1, 2);
    #1;
    total++;
    if (bs.in_ready !== 4'b0100) begin bad++; $display("FAIL sel2_rdy got=%b want=0100", bs.in_ready); end
    drv_s(2'd0, 4'b1111, 32'h44332211, 1'b1, 0);
    #1;
    total++;
    if (bs.in_ready !== 4'b0001) begin bad++; $display("FAIL sel0_rdy got=%b want=0001", bs.in_ready); end
    drv_s(2'd0, 4'b0000, 32'h0, 1'b1, -1);
  endtask

  task automatic test_sel_invalid();
    drv_s(2'd0, 4'b1101, 32'h55667788, 1'b1, 0);
    drv_s(2'd1, 4'b1101, 32'h55667788, 1'b1, -1);
    #1;
    total++;
    if (bs.in_ready !== 4'b0000) begin bad++; $display("FAIL selinv_rdy got=%b want=0000", bs.in_ready); end
    drv_s(2'd1, 4'b0000, 32'h0, 1'b1, -1);
  endtask

  task automatic test_sel_nch3();
    for (int i = 0; i < 2; i++) begin
      drv_3(2'd3, 3'b111, 24'h332211, 1'b1, -1);
      #1;
      total++;
      if (b3.in_ready !== 3'b000) begin bad++; $display("FAIL nch3_sel3_rdy got=%b want=000", b3.in_ready); end
    end
    drv_3(2'd2, 3'b111, 24'h332211, 1'b1, 2);
    #1;
    total++;
    if (b3.in_ready !== 3'b100) begin bad++; $display("FAIL nch3_sel2_rdy got=%b want=100", b3.in_ready); end
    drv_3(2'd3, 3'b111, 24'h665544, 1'b1, -1);
    drv_3(2'd0, 3'b000, 24'h0, 1'b1, -1);
  endtask

  task automatic test_rr_fair();
    logic [3:0] e;
    int         seq[4] = '{1, 3, 1, 3};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv_r(4'b1111, 32'h44332211 + 32'(i), 1'b1, i % 4);
      #1;
      e = 4'b0001 << (i % 4);
      total++;
      if (br.in_ready !== e) begin bad++; $display("FAIL rr_all_rdy[%0d] got=%b want=%b", i, br.in_ready, e); end
    end
    for (int i = 0; i < 4; i++) begin
      drv_r(4'b1010, 32'h9A8B7C6D, 1'b1, seq[i]);
      #1;
      e = 4'b0001 << seq[i];
      total++;
      if (br.in_ready !== e) begin bad++; $display("FAIL rr_1010_rdy[%0d] got=%b want=%b", i, br.in_ready, e); end
    end
    drv_r(4'b0000, 32'h0, 1'b1, -1);
  endtask

  task automatic test_backpressure();
    drv_r(4'b0100, 32'h00A50000, 1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      drv_r(4'b1111, 32'h10203040 * 32'(i + 1), 1'b0, -1);
      #1;
      total += 3;
      if (br.in_ready !== 4'b0) begin bad++; $display("FAIL bp_rdy[%0d] got=%b want=0000", i, br.in_ready); end
      if (br.out_data !== 8'hA5) begin bad++; $display("FAIL bp_data[%0d] got=%h want=a5", i, br.out_data); end
      if (br.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, br.out_valid); end
    end
    drv_r(4'b1111, 32'hC3B2A190, 1'b1, 3);
    #1;
    total++;
    if (br.in_ready !== 4'b1000) begin bad++; $display("FAIL bp_resume_rdy got=%b want=1000", br.in_ready); end
    drv_r(4'b0000, 32'h0, 1'b1, -1);
  endtask

  task automatic test_async_reset();
    drv_r(4'b1111, 32'h88776655, 1'b1, 0);
    drv_r(4'b1111, 32'h88776655, 1'b1, 1);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (br.out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", br.out_valid); end
    if (br.out_data !== 8'h00) begin bad++; $display("FAIL arst_data got=%h want=00", br.out_data); end
    if (br.out_ch !== 2'd0) begin bad++; $display("FAIL arst_ch got=%0d want=0", br.out_ch); end
    if (br.in_ready !== 4'b0) begin bad++; $display("FAIL arst_rdy got=%b want=0000", br.in_ready); end
    br.in_valid = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drv_r(4'b1111, 32'h0F1E2D3C, 1'b1, 0);
    #1;
    total++;
    if (br.in_ready !== 4'b0001) begin bad++; $display("FAIL arst_first_rdy got=%b want=0001", br.in_ready); end
    drv_r(4'b0000, 32'h0, 1'b1, -1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bs.in_data = 32'h44332211; bs.in_valid = 4'b1111; bs.sel = '0; bs.out_ready = 1'b1;
    br.in_data = 32'h44332211; br.in_valid = 4'b1111; br.sel = '0; br.out_ready = 1'b1;
    b3.in_data = 24'h332211;   b3.in_valid = 3'b111;  b3.sel = '0; b3.out_ready = 1'b1;
    test_reset();
    test_sel_basic();
    test_sel_invalid();
    test_sel_nch3();
    test_rr_fair();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
